// File: rtl/aes_round_key_buffer.sv
// aes_round_key_buffer: loads an AES key schedule as a serial stream and replays it as 128-bit round keys.
// The optional key wipe (zeroise input, zbusy output) is built only when AES_KEYBUF_ZEROISE_EN is defined.
module aes_round_key_buffer #(
    parameter int BUS_W      = 8,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             loaded,
    input  logic             start,
    input  logic             dir,
    output logic [127:0]     out_key,
    output logic [3:0]       out_round,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
`ifdef AES_KEYBUF_ZEROISE_EN
    input  logic             zeroise,
    output logic             zbusy,
`endif
    output logic [1:0]       dbg_state
);
    localparam int             BEATS     = 128 / BUS_W;
    localparam int             BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [3:0]     LAST_KEY  = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FULL = 2'd1,
        S_READ = 2'd2,
        S_ZERO = 2'd3
    } state_e;

    state_e         state_q;
    logic [BCW-1:0] beat_q;
    logic [3:0]     kidx_q;
    logic [3:0]     zidx_q;
    logic           dir_q;
    logic [127:0]   asm_q;
    logic [127:0]   asm_d;
    logic [127:0]   out_key_q;
    logic [3:0]     out_round_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic           loaded_q;
    logic [127:0]   key_mem [0:NUM_ROUNDS];

    logic           wipe_req;
    logic           load_fire;
    logic [3:0]     next_round;
    logic [3:0]     end_round;
    logic           key_we;
    logic [3:0]     key_waddr;
    logic [127:0]   key_wdata;

`ifdef AES_KEYBUF_ZEROISE_EN
    assign wipe_req = zeroise;
    assign zbusy    = (state_q == S_ZERO);
`else
    assign wipe_req = 1'b0;
`endif

    // Both ports use plain valid/ready: a beat or key moves on a rising edge where valid, ready
    // and enable are all high; the producer holds its data stable until that edge.
    assign in_ready  = enable & (state_q == S_LOAD);
    assign load_fire = in_valid & in_ready & ~clear & ~wipe_req;

    // Beats enter at the LSB end, so the first beat of a key finishes in the top bits.
    if (BUS_W == 128) begin : g_full_word
        assign asm_d = in_data;
    end else begin : g_shift
        assign asm_d = {asm_q[127-BUS_W:0], in_data};
    end

    assign next_round = dir_q ? (out_round_q - 4'd1) : (out_round_q + 4'd1);
    assign end_round  = dir_q ? 4'd0 : LAST_KEY;

    always_comb begin
        key_we    = 1'b0;
        key_waddr = kidx_q;
        key_wdata = asm_d;
        if (state_q == S_ZERO) begin
            key_we    = 1'b1;
            key_waddr = zidx_q;
            key_wdata = '0;
        end else if (load_fire && (beat_q == LAST_BEAT)) begin
            key_we = 1'b1;
        end
    end

    // Key storage carries no reset so it maps onto plain RAM/flops without a reset net.
    always_ff @(posedge clock) begin
        if (key_we) begin
            key_mem[key_waddr] <= key_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            beat_q      <= '0;
            kidx_q      <= '0;
            zidx_q      <= '0;
            dir_q       <= 1'b0;
            asm_q       <= '0;
            out_key_q   <= '0;
            out_round_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            loaded_q    <= 1'b0;
        end else if (wipe_req) begin
            state_q     <= S_ZERO;
            zidx_q      <= '0;
            beat_q      <= '0;
            kidx_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            loaded_q    <= 1'b0;
        end else if (state_q == S_ZERO) begin
            if (zidx_q == LAST_KEY) begin
                state_q <= S_LOAD;
                zidx_q  <= '0;
            end else begin
                zidx_q <= zidx_q + 4'd1;
            end
        end else if (clear) begin
            state_q     <= S_LOAD;
            beat_q      <= '0;
            kidx_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            loaded_q    <= 1'b0;
        end else if (enable) begin
            case (state_q)
                S_LOAD: begin
                    if (load_fire) begin
                        asm_q <= asm_d;
                        if (beat_q == LAST_BEAT) begin
                            beat_q <= '0;
                            if (kidx_q == LAST_KEY) begin
                                kidx_q   <= '0;
                                state_q  <= S_FULL;
                                loaded_q <= 1'b1;
                            end else begin
                                kidx_q <= kidx_q + 4'd1;
                            end
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (start) begin
                        state_q     <= S_READ;
                        dir_q       <= dir;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        out_round_q <= dir ? LAST_KEY : 4'd0;
                        out_key_q   <= key_mem[dir ? LAST_KEY : 4'd0];
                    end
                end
                S_READ: begin
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            state_q     <= S_FULL;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_round_q <= next_round;
                            out_key_q   <= key_mem[next_round];
                            out_last_q  <= (next_round == end_round);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign loaded    = loaded_q;
    assign out_key   = out_key_q;
    assign out_round = out_round_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_key_buffer.sv
// Bench for aes_round_key_buffer: 8-bit instance driven with FIPS-197 and random schedules,
// plus a 32-bit instance for the wide-bus load path; replays are compared to an array model.
module tb_aes_round_key_buffer;
    localparam int NR    = 10;
    localparam int NBYTE = 16 * (NR + 1);

    logic         clock = 1'b0;
    logic         reset;
    logic         enable, clear, in_valid, in_ready, loaded, start, dir;
    logic [7:0]   in_data;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_valid, out_last, out_ready;
    logic [1:0]   dbg_state;

    logic         enable_b, clear_b, in_valid_b, in_ready_b, loaded_b, start_b, dir_b;
    logic [31:0]  in_data_b;
    logic [127:0] out_key_b;
    logic [3:0]   out_round_b;
    logic         out_valid_b, out_last_b, out_ready_b;
    logic [1:0]   dbg_state_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] ref_keys [0:NR];
    logic [127:0] exp_q[$];
    logic [127:0] obs_key[$];
    logic [3:0]   obs_round[$];
    logic         obs_last[$];

    aes_round_key_buffer #(.BUS_W(8), .NUM_ROUNDS(NR)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .loaded(loaded),
        .start(start), .dir(dir), .out_key(out_key), .out_round(out_round),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .dbg_state(dbg_state)
    );

    aes_round_key_buffer #(.BUS_W(32), .NUM_ROUNDS(NR)) u_dut32 (
        .clock(clock), .reset(reset), .enable(enable_b), .clear(clear_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .loaded(loaded_b),
        .start(start_b), .dir(dir_b), .out_key(out_key_b), .out_round(out_round_b),
        .out_valid(out_valid_b), .out_last(out_last_b), .out_ready(out_ready_b), .dbg_state(dbg_state_b)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    task automatic set_fips();
        ref_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ref_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ref_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ref_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ref_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ref_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ref_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ref_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ref_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ref_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ref_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    endtask

    task automatic set_random();
        for (int k = 0; k <= NR; k++) ref_keys[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic [7:0] ref_byte(input int idx);
        logic [127:0] k;
        k = ref_keys[idx / 16];
        return k[127 - 8 * (idx % 16) -: 8];
    endfunction

    // Replay order is just the key list walked forwards or backwards.
    task automatic build_expected(input logic d);
        exp_q.delete();
        for (int r = 0; r <= NR; r++) exp_q.push_back(ref_keys[d ? NR - r : r]);
    endtask

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic load_keys(input int valid_pct, input int en_pct,
                             output int cycles, output bit timed_out, output bit early);
        int idx;
        idx = 0; cycles = 0; early = 0;
        while (idx < NBYTE && cycles < 3000) begin
            enable   = ($urandom_range(0, 99) < en_pct);
            in_valid = ($urandom_range(0, 99) < valid_pct);
            in_data  = ref_byte(idx);
            #1;
            if (loaded === 1'b1) early = 1;
            if (in_valid && in_ready) idx++;
            cycles++;
            @(negedge clock);
        end
        enable = 1'b1; in_valid = 1'b0;
        timed_out = (idx < NBYTE);
    endtask

    task automatic run_replay(input logic d, input int rdy_pct, input int en_pct, input bit poke,
                              output bit lat_ok, output int unstable, output int cycles,
                              output bit timed_out);
        logic [127:0] pk;
        logic [3:0]   pr;
        logic         pl;
        bit           hold, done;
        obs_key.delete(); obs_round.delete(); obs_last.delete();
        unstable = 0; cycles = 0; hold = 0; done = 0; pk = '0; pr = '0; pl = 1'b0;
        enable = 1'b1; dir = d; start = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        start  = 1'b0;
        lat_ok = (out_valid === 1'b1) && (out_round === (d ? 4'(NR) : 4'd0));
        while (!done && cycles < 2000) begin
            if (hold && (out_valid !== 1'b1 || out_key !== pk || out_round !== pr || out_last !== pl))
                unstable++;
            enable    = ($urandom_range(0, 99) < en_pct);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            start     = poke && ($urandom_range(0, 99) < 20);
            dir       = 1'($urandom);
            #1;
            hold = 0;
            if (out_valid && out_ready && enable) begin
                obs_key.push_back(out_key);
                obs_round.push_back(out_round);
                obs_last.push_back(out_last);
                if (out_last) done = 1;
            end else if (out_valid) begin
                hold = 1; pk = out_key; pr = out_round; pl = out_last;
            end
            cycles++;
            @(negedge clock);
        end
        start = 1'b0; out_ready = 1'b0; enable = 1'b1;
        timed_out = !done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        n_tests++; if (out_key !== 128'h0) begin n_fail++; $display("FAIL rst_out_key: got %h want 0", out_key); end
        n_tests++; if (out_round !== 4'd0) begin n_fail++; $display("FAIL rst_out_round: got %0d want 0", out_round); end
        n_tests++; if (loaded !== 1'b0) begin n_fail++; $display("FAIL rst_loaded: got %b want 0", loaded); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        enable = 1'b0; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_en0: got %b want 0", in_ready); end
        enable = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start = 1'b1; dir = 1'b0;
        @(negedge clock);
        start = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL start_in_load: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_load_fips();
        int cyc; bit to, early;
        set_fips();
        load_keys(100, 100, cyc, to, early);
        n_tests++; if (to) begin n_fail++; $display("FAIL fips_load_timeout: got timeout want none"); end
        n_tests++; if (cyc != NBYTE) begin n_fail++; $display("FAIL fips_load_cycles: got %0d want %0d", cyc, NBYTE); end
        n_tests++; if (early) begin n_fail++; $display("FAIL fips_loaded_early: got loaded before last beat want 0"); end
        n_tests++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL fips_loaded: got %b want 1", loaded); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); #1;
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
            @(negedge clock);
        end
        in_valid = 1'b0;
        n_tests++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL full_loaded_hold: got %b want 1", loaded); end
    endtask

    task automatic test_replay_dec();
        bit lat, to; int unst, cyc;
        run_replay(1'b1, 100, 100, 1'b0, lat, unst, cyc, to);
        build_expected(1'b1);
        n_tests++; if (to || !lat) begin n_fail++; $display("FAIL dec_start: got timeout %b latency_ok %b want 0 1", to, lat); end
        n_tests++; if (cyc != NR + 1) begin n_fail++; $display("FAIL dec_cycles: got %0d want %0d", cyc, NR + 1); end
        n_tests++; if (obs_key.size() != NR + 1) begin n_fail++; $display("FAIL dec_count: got %0d want %0d", obs_key.size(), NR + 1); end
        if (obs_key.size() == NR + 1) begin
            n_tests++; if (obs_key[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL dec_first_key: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", obs_key[0]); end
            n_tests++; if (obs_key[1] !== 128'hac7766f319fadc2128d12941575c006e) begin n_fail++; $display("FAIL dec_second_key: got %h want ac7766f319fadc2128d12941575c006e", obs_key[1]); end
            n_tests++; if (obs_key[NR] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin n_fail++; $display("FAIL dec_final_key: got %h want 2b7e151628aed2a6abf7158809cf4f3c", obs_key[NR]); end
        end
        for (int i = 0; i < obs_key.size() && i <= NR; i++) begin
            n_tests++;
            if (obs_key[i] !== exp_q[i] || obs_round[i] !== 4'(NR - i) || obs_last[i] !== (i == NR)) begin
                n_fail++;
                $display("FAIL dec_seq[%0d]: got key %h round %0d last %b, want key %h round %0d last %b",
                         i, obs_key[i], obs_round[i], obs_last[i], exp_q[i], NR - i, (i == NR));
            end
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_done_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        enable = 1'b1; start = 1'b1; dir = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_round !== 4'd1 || out_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid %b round %0d key %h want 1 1 a0fafe1788542cb123a339392a6c7605", i, out_valid, out_round, out_key);
            end
            @(negedge clock);
        end
        out_ready = 1'b1;
        for (int r = 1; r <= NR; r++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_round !== 4'(r) || out_key !== ref_keys[r] || out_last !== (r == NR)) begin
                n_fail++;
                $display("FAIL stall_resume[%0d]: got valid %b round %0d key %h last %b want 1 %0d %h %b", r, out_valid, out_round, out_key, out_last, r, ref_keys[r], (r == NR));
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_done_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_random_replays();
        int cyc, unst; bit to, early, lat; logic d;
        clear = 1'b1; @(negedge clock); clear = 1'b0;
        set_random();
        load_keys(70, 90, cyc, to, early);
        n_tests++; if (to || early || loaded !== 1'b1) begin n_fail++; $display("FAIL rand_load: got timeout %b early %b loaded %b want 0 0 1", to, early, loaded); end
        for (int t = 0; t < 6; t++) begin
            d = 1'($urandom);
            run_replay(d, 60, 85, 1'b1, lat, unst, cyc, to);
            build_expected(d);
            n_tests++; if (to || !lat || unst != 0) begin n_fail++; $display("FAIL rand_replay%0d: got timeout %b latency_ok %b unstable %0d want 0 1 0", t, to, lat, unst); end
            n_tests++; if (obs_key.size() != NR + 1) begin n_fail++; $display("FAIL rand_count%0d: got %0d want %0d", t, obs_key.size(), NR + 1); end
            for (int i = 0; i < obs_key.size() && i <= NR; i++) begin
                n_tests++;
                if (obs_key[i] !== exp_q[i] || obs_round[i] !== 4'(d ? NR - i : i) || obs_last[i] !== (i == NR)) begin
                    n_fail++;
                    $display("FAIL rand_seq%0d[%0d]: got key %h round %0d last %b, want key %h round %0d last %b",
                             t, i, obs_key[i], obs_round[i], obs_last[i], exp_q[i], d ? NR - i : i, (i == NR));
                end
            end
        end
    endtask

    task automatic test_enable_freeze();
        int cyc, unst; bit to, early, lat;
        clear = 1'b1; @(negedge clock); clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enable = 1'b0; in_valid = 1'b1; in_data = 8'($urandom); #1;
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en0_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(negedge clock);
        end
        in_valid = 1'b0; enable = 1'b1;
        set_random();
        load_keys(100, 100, cyc, to, early);
        n_tests++; if (to || early || cyc != NBYTE || loaded !== 1'b1) begin n_fail++; $display("FAIL en0_reload: got timeout %b early %b cycles %0d loaded %b want 0 0 %0d 1", to, early, cyc, loaded, NBYTE); end
        run_replay(1'b0, 80, 70, 1'b0, lat, unst, cyc, to);
        build_expected(1'b0);
        n_tests++; if (to || !lat || unst != 0 || obs_key.size() != NR + 1) begin n_fail++; $display("FAIL en0_replay: got timeout %b latency_ok %b unstable %0d count %0d want 0 1 0 %0d", to, lat, unst, obs_key.size(), NR + 1); end
        for (int i = 0; i < obs_key.size() && i <= NR; i++) begin
            n_tests++;
            if (obs_key[i] !== exp_q[i] || obs_round[i] !== 4'(i) || obs_last[i] !== (i == NR)) begin
                n_fail++;
                $display("FAIL en0_seq[%0d]: got key %h round %0d last %b, want key %h round %0d last %b", i, obs_key[i], obs_round[i], obs_last[i], exp_q[i], i, (i == NR));
            end
        end
    endtask

    task automatic test_clear();
        int cyc, unst; bit to, early, lat;
        clear = 1'b1; @(negedge clock); clear = 1'b0;
        set_random();
        for (int b = 0; b < 5; b++) begin
            enable = 1'b1; in_valid = 1'b1; in_data = ref_byte(b); #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_partial_ready[%0d]: got %b want 1", b, in_ready); end
            @(negedge clock);
        end
        in_valid = 1'b1; in_data = ~ref_byte(5); clear = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; clear = 1'b0;
        n_tests++; if (loaded !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_state: got loaded %b out_valid %b in_ready %b want 0 0 1", loaded, out_valid, in_ready); end
        load_keys(80, 100, cyc, to, early);
        n_tests++; if (to || early || loaded !== 1'b1) begin n_fail++; $display("FAIL clr_reload: got timeout %b early %b loaded %b want 0 0 1", to, early, loaded); end
        run_replay(1'b1, 75, 100, 1'b1, lat, unst, cyc, to);
        build_expected(1'b1);
        n_tests++; if (to || !lat || unst != 0 || obs_key.size() != NR + 1) begin n_fail++; $display("FAIL clr_replay: got timeout %b latency_ok %b unstable %0d count %0d want 0 1 0 %0d", to, lat, unst, obs_key.size(), NR + 1); end
        for (int i = 0; i < obs_key.size() && i <= NR; i++) begin
            n_tests++;
            if (obs_key[i] !== exp_q[i] || obs_round[i] !== 4'(NR - i) || obs_last[i] !== (i == NR)) begin
                n_fail++;
                $display("FAIL clr_seq[%0d]: got key %h round %0d last %b, want key %h round %0d last %b", i, obs_key[i], obs_round[i], obs_last[i], exp_q[i], NR - i, (i == NR));
            end
        end
        start = 1'b1; dir = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || loaded !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_mid_replay: got out_valid %b loaded %b in_ready %b want 0 0 1", out_valid, loaded, in_ready); end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_start_ignored: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_replay();
        int cyc; bit to, early;
        set_fips();
        load_keys(100, 100, cyc, to, early);
        n_tests++; if (to || loaded !== 1'b1) begin n_fail++; $display("FAIL rmr_load: got timeout %b loaded %b want 0 1", to, loaded); end
        start = 1'b1; dir = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++; if (out_valid !== 1'b1 || out_round !== 4'd3) begin n_fail++; $display("FAIL rmr_before: got valid %b round %0d want 1 3", out_valid, out_round); end
        #1 reset = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || loaded !== 1'b0 || out_key !== 128'h0 || out_round !== 4'd0) begin n_fail++; $display("FAIL rmr_async: got valid %b loaded %b key %h round %0d want 0 0 0 0", out_valid, loaded, out_key, out_round); end
        @(negedge clock);
        reset = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_after: got in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_bus32();
        int idx, cyc; logic [127:0] k;
        set_fips();
        idx = 0; cyc = 0;
        while (idx < 4 * (NR + 1) && cyc < 500) begin
            k = ref_keys[idx / 4];
            enable_b = 1'b1; in_valid_b = 1'b1; in_data_b = k[127 - 32 * (idx % 4) -: 32]; #1;
            if (in_ready_b) idx++;
            cyc++;
            @(negedge clock);
        end
        in_valid_b = 1'b0;
        n_tests++; if (cyc != 4 * (NR + 1) || loaded_b !== 1'b1) begin n_fail++; $display("FAIL b32_load: got cycles %0d loaded %b want %0d 1", cyc, loaded_b, 4 * (NR + 1)); end
        start_b = 1'b1; dir_b = 1'b0; out_ready_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        n_tests++; if (out_valid_b !== 1'b1 || out_round_b !== 4'd0 || out_key_b !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin n_fail++; $display("FAIL b32_first: got valid %b round %0d key %h want 1 0 2b7e151628aed2a6abf7158809cf4f3c", out_valid_b, out_round_b, out_key_b); end
        for (int r = 0; r <= NR; r++) begin
            n_tests++;
            if (out_valid_b !== 1'b1 || out_round_b !== 4'(r) || out_key_b !== ref_keys[r] || out_last_b !== (r == NR)) begin
                n_fail++;
                $display("FAIL b32_seq[%0d]: got valid %b round %0d key %h last %b want 1 %0d %h %b", r, out_valid_b, out_round_b, out_key_b, out_last_b, r, ref_keys[r], (r == NR));
            end
            @(negedge clock);
        end
        out_ready_b = 1'b0;
        n_tests++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL b32_done_valid: got %b want 0", out_valid_b); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0;
        start = 1'b0; dir = 1'b0; out_ready = 1'b0;
        enable_b = 1'b1; clear_b = 1'b0; in_data_b = '0; in_valid_b = 1'b0;
        start_b = 1'b0; dir_b = 1'b0; out_ready_b = 1'b0;
        test_reset();
        test_load_fips();
        test_replay_dec();
        test_stall();
        test_random_replays();
        test_enable_freeze();
        test_clear();
        test_reset_mid_replay();
        test_bus32();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
